key_filter: RTL and testbench

- Input-side counterpart to the board's LED output drivers: reads KEY_W active-low push buttons, synchronises and debounces them.
- Delivers clean single-cycle press/release events plus debounced levels to the LED-pattern and mode-control logic.
- Runs in the 125 MHz clock domain.
- Default filter window is 20 ms of stable input.

---
 rtl/key_filter_pkg.sv | 13 +
 rtl/key_debounce_1.sv | 104 ++++++++++
 rtl/key_filter.sv | 59 +++++
 tb/tb_key_filter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/key_filter_pkg.sv
// key_filter_pkg: one-hot debounce FSM encodings and default filter window
// shared by the key filter top level and its per-key debouncer.
package key_filter_pkg;

    localparam logic [3:0] ST_IDLE       = 4'b0001;
    localparam logic [3:0] ST_PRESS_FILT = 4'b0010;
    localparam logic [3:0] ST_DOWN       = 4'b0100;
    localparam logic [3:0] ST_REL_FILT   = 4'b1000;

    // 2_500_000 cycles of stable input = 20 ms at 125 MHz
    localparam logic [31:0] CNT_20MS_MAX_DEF = 32'd2_499_999;

endpackage

// File: rtl/key_debounce_1.sv
// key_debounce_1: single-key 2-FF synchroniser, stability counter and
// four-state debounce FSM producing a registered level and event strobes.
module key_debounce_1
    import key_filter_pkg::*;
#(
    parameter logic [31:0] CNT_20MS_MAX = CNT_20MS_MAX_DEF
) (
    input  logic clk_125mhz,
    input  logic rst,
    input  logic key_in,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    logic [1:0]  r_sync;
    logic [3:0]  r_state;
    logic [31:0] r_cnt;
    logic        r_level;
    logic [3:0]  w_state_nxt;
    logic [31:0] w_cnt_nxt;
    logic        w_ks;
    logic        w_done;

    assign w_ks   = r_sync[1];
    assign w_done = (r_cnt == CNT_20MS_MAX);
    assign level  = r_level;

    always_ff @(posedge clk_125mhz or negedge rst) begin
        if (!rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], key_in};
        end
    end

    // Strobes are combinational so the top level can register flags and
    // key_value on the same edge that updates the level.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        press_pulse   = 1'b0;
        release_pulse = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_ks) begin
                    w_state_nxt = ST_PRESS_FILT;
                    w_cnt_nxt   = 32'd0;
                end
            end
            ST_PRESS_FILT: begin
                if (w_ks) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 32'd0;
                end else if (w_done) begin
                    w_state_nxt = ST_DOWN;
                    w_cnt_nxt   = 32'd0;
                    press_pulse = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            ST_DOWN: begin
                if (w_ks) begin
                    w_state_nxt = ST_REL_FILT;
                    w_cnt_nxt   = 32'd0;
                end
            end
            ST_REL_FILT: begin
                if (!w_ks) begin
                    w_state_nxt = ST_DOWN;
                    w_cnt_nxt   = 32'd0;
                end else if (w_done) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = 32'd0;
                    release_pulse = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk_125mhz or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 32'd0;
            r_level <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (press_pulse) begin
                r_level <= 1'b0;
            end else if (release_pulse) begin
                r_level <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_filter.sv
// key_filter: debounces KEY_W active-low buttons and reports registered
// press/release strobes plus the one-hot code of the latest pressed key.
module key_filter
    import key_filter_pkg::*;
#(
    parameter logic [31:0] CNT_20MS_MAX = CNT_20MS_MAX_DEF,
    parameter int          KEY_W        = 4
) (
    input  logic             clk_125mhz,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_level,
    output logic             press_flag,
    output logic             release_flag,
    output logic [KEY_W-1:0] key_value
);

    logic [KEY_W-1:0] w_press;
    logic [KEY_W-1:0] w_release;
    logic [KEY_W-1:0] w_first;
    logic             r_press_flag;
    logic             r_release_flag;
    logic [KEY_W-1:0] r_key_value;

    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        key_debounce_1 #(
            .CNT_20MS_MAX(CNT_20MS_MAX)
        ) u_deb (
            .clk_125mhz   (clk_125mhz),
            .rst          (rst),
            .key_in       (key_in[g]),
            .level        (key_level[g]),
            .press_pulse  (w_press[g]),
            .release_pulse(w_release[g])
        );
    end

    // Isolate the lowest set bit so simultaneous presses favour key 0.
    assign w_first = w_press & (~w_press + KEY_W'(1));

    always_ff @(posedge clk_125mhz or negedge rst) begin
        if (!rst) begin
            r_press_flag   <= 1'b0;
            r_release_flag <= 1'b0;
            r_key_value    <= '0;
        end else begin
            r_press_flag   <= |w_press;
            r_release_flag <= |w_release;
            if (|w_press) begin
                r_key_value <= w_first;
            end
        end
    end

    assign press_flag   = r_press_flag;
    assign release_flag = r_release_flag;
    assign key_value    = r_key_value;

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: directed and random stimulus against a run-length model of
// the debouncer (a level flips after CNT+2 consecutive disagreeing samples).
module tb_key_filter;

    localparam int M = 9;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] key_in = '1;
    logic [W-1:0] key_level;
    logic         press_flag;
    logic         release_flag;
    logic [W-1:0] key_value;

    int n_assert = 0;
    int n_fail   = 0;
    int press_cnt;
    int release_cnt;

    logic [W-1:0] m_s1, m_s2, m_lvl, m_val;
    logic         m_pf, m_rf;
    int           m_run[W];

    key_filter #(.CNT_20MS_MAX(32'd9), .KEY_W(W)) dut (
        .clk_125mhz  (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .press_flag  (press_flag),
        .release_flag(release_flag),
        .key_value   (key_value)
    );

    always #4 clk = ~clk;

    task automatic model_reset();
        m_s1 = '1;
        m_s2 = '1;
        m_lvl = '1;
        m_val = '0;
        m_pf = 1'b0;
        m_rf = 1'b0;
        for (int i = 0; i < W; i++) m_run[i] = 0;
    endtask

    task automatic model_edge(input logic [W-1:0] k);
        logic [W-1:0] ks, pe, re;
        ks = m_s2;
        m_s2 = m_s1;
        m_s1 = k;
        pe = '0;
        re = '0;
        for (int i = 0; i < W; i++) begin
            m_run[i] = (ks[i] != m_lvl[i]) ? m_run[i] + 1 : 0;
            if (m_run[i] == M + 2) begin
                m_run[i] = 0;
                if (m_lvl[i]) pe[i] = 1'b1;
                else re[i] = 1'b1;
                m_lvl[i] = ~m_lvl[i];
            end
        end
        m_pf = |pe;
        m_rf = |re;
        for (int i = W - 1; i >= 0; i--) if (pe[i]) m_val = 4'b0001 << i;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "/key_level"}, key_level, m_lvl);
        chk({tag, "/press_flag"}, {3'b000, press_flag}, {3'b000, m_pf});
        chk({tag, "/release_flag"}, {3'b000, release_flag}, {3'b000, m_rf});
        chk({tag, "/key_value"}, key_value, m_val);
    endtask

    task automatic cyc(input logic [W-1:0] k, input string tag);
        key_in = k;
        @(posedge clk);
        if (rst) model_edge(k);
        else model_reset();
        #1;
        check_model(tag);
        if (press_flag) press_cnt++;
        if (release_flag) release_cnt++;
    endtask

    initial begin
        int rem[W];
        logic [W-1:0] rk;
        model_reset();
        repeat (3) cyc(4'hF, "reset");
        chk("reset_level", key_level, 4'b1111);
        chk("reset_value", key_value, 4'b0000);
        rst = 1'b1;

        repeat (100) cyc(4'hF, "idle");

        press_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            cyc(4'b1011, "k2_press");
            chk("k2_press_timing", {3'b000, press_flag}, {3'b000, t == 12});
        end
        chk("k2_press_count", 4'(press_cnt), 4'd1);
        chk("k2_value", key_value, 4'b0100);
        chk("k2_level", key_level, 4'b1011);

        repeat (20) cyc(4'hF, "k2_release");
        press_cnt = 0;
        for (int t = 0; t < 40; t++) cyc(((t / 4) % 2 == 0) ? 4'b1011 : 4'hF, "k2_toggle");
        repeat (20) cyc(4'hF, "k2_settle");
        chk("toggle_press_count", 4'(press_cnt), 4'd0);
        chk("toggle_level", key_level, 4'b1111);
        chk("toggle_value", key_value, 4'b0100);

        press_cnt = 0;
        repeat (20) cyc(4'b0110, "k03_press");
        chk("k03_press_count", 4'(press_cnt), 4'd1);
        chk("k03_value", key_value, 4'b0001);
        chk("k03_level", key_level, 4'b0110);

        repeat (20) cyc(4'hF, "k03_release");
        repeat (20) cyc(4'b1101, "k1_press");
        repeat (3) cyc(4'hF, "k1_bounce_hi");
        repeat (2) cyc(4'b1101, "k1_bounce_lo");
        release_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            cyc(4'hF, "k1_release");
            chk("k1_release_timing", {3'b000, release_flag}, {3'b000, t == 12});
        end
        chk("k1_release_count", 4'(release_cnt), 4'd1);
        chk("k1_level", key_level, 4'b1111);
        chk("k1_value_kept", key_value, 4'b0010);

        repeat (8) cyc(4'b1110, "k0_filter");
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_level", key_level, 4'b1111);
        chk("async_rst_flags", {2'b00, press_flag, release_flag}, 4'b0000);
        chk("async_rst_value", key_value, 4'b0000);
        repeat (3) cyc(4'b1110, "k0_in_reset");
        rst = 1'b1;
        press_cnt = 0;
        for (int t = 0; t < 20; t++) begin
            cyc(4'b1110, "k0_restart");
            chk("k0_restart_timing", {3'b000, press_flag}, {3'b000, t == 12});
        end
        chk("k0_restart_count", 4'(press_cnt), 4'd1);

        for (int i = 0; i < W; i++) rem[i] = 0;
        rk = 4'hF;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < W; i++) begin
                if (rem[i] == 0) begin
                    rk[i] = ~rk[i];
                    rem[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 6) : $urandom_range(8, 30);
                end
                rem[i]--;
            end
            cyc(rk, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
